// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator behind a 2-entry valid/ready skid buffer.
// Each entry carries {illegal, tag, immediate}; outputs come straight from the head register.
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immext,
    output logic             illegal,
    output logic [TAG_W-1:0] tag_out,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int ENT_W = 1 + TAG_W + XLEN;

    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

    state_t           state_q, state_d;
    logic [ENT_W-1:0] head_q, head_d;
    logic [ENT_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [31:0]      raw_imm;
    logic             new_ill;
    logic [XLEN-1:0]  new_imm;
    logic [ENT_W-1:0] new_ent;
    logic             push;
    logic             pop;
    logic             unused_instr;

    assign unused_instr = ^instr[6:0];

    // Every format is first built as a 32-bit value whose bit 31 is the correct
    // extension bit, so one sign-extension covers both XLEN settings.
    always_comb begin
        raw_imm = 32'd0;
        new_ill = 1'b0;
        case (immsrc)
            3'b000: raw_imm = {{20{instr[31]}}, instr[31:20]};
            3'b001: raw_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: raw_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011: raw_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b100: raw_imm = {instr[31:12], 12'd0};
            3'b101: raw_imm = {27'd0, instr[19:15]};
            3'b110: raw_imm = {26'd0, (XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
            default: new_ill = 1'b1;
        endcase
    end

    assign new_imm = XLEN'($signed(raw_imm));
    assign new_ent = {new_ill, tag_in, new_imm};

    assign in_ready  = !reset && (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        err_cnt_d = err_cnt_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) begin
                    head_d  = new_ent;
                    state_d = HALF;
                end
                HALF: begin
                    if (push && pop) begin
                        head_d = new_ent;
                    end else if (push) begin
                        tail_d  = new_ent;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    head_d  = tail_q;
                    state_d = HALF;
                end
                default: state_d = EMPTY;
            endcase
        end
        if (push && new_ill && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            head_q    <= '0;
            tail_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign immext  = head_q[XLEN-1:0];
    assign tag_out = head_q[XLEN +: TAG_W];
    assign illegal = head_q[ENT_W-1];
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench: two instances (XLEN=32/CNT_W=8 and XLEN=64/CNT_W=2) share one stimulus stream.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instr, tag_in;
    logic [2:0]  immsrc;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [31:0] a_immext, a_tag_out;
    logic [7:0]  a_err_cnt;
    logic        b_in_ready, b_out_valid, b_illegal;
    logic [63:0] b_immext;
    logic [31:0] b_tag_out;
    logic [1:0]  b_err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(8)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .instr(instr), .immsrc(immsrc), .tag_in(tag_in), .out_valid(a_out_valid),
        .out_ready(out_ready), .immext(a_immext), .illegal(a_illegal), .tag_out(a_tag_out),
        .err_cnt(a_err_cnt)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(2)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .instr(instr), .immsrc(immsrc), .tag_in(tag_in), .out_valid(b_out_valid),
        .out_ready(out_ready), .immext(b_immext), .illegal(b_illegal), .tag_out(b_tag_out),
        .err_cnt(b_err_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [31:0] tg);
        in_valid = v;
        instr    = ins;
        immsrc   = src;
        tag_in   = tg;
    endtask

    task automatic head(input string nm, input logic [31:0] e32, input logic [63:0] e64,
                        input logic ill, input logic [31:0] tg);
        chk({nm, "_valid32"}, 64'(a_out_valid), 64'd1);
        chk({nm, "_valid64"}, 64'(b_out_valid), 64'd1);
        chk({nm, "_imm32"}, 64'(a_immext), 64'(e32));
        chk({nm, "_imm64"}, b_immext, e64);
        chk({nm, "_ill"}, 64'(a_illegal), 64'(ill));
        chk({nm, "_tag"}, 64'(a_tag_out), 64'(tg));
        $display("txn %s imm32=%h imm64=%h ill=%0b tag=%h", nm, a_immext, b_immext, a_illegal, a_tag_out);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 3'b000, 32'h99);
        cycle(); cycle();
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_immext", b_immext, 64'd0);
        chk("rst_tag", 64'(a_tag_out), 64'd0);
        chk("rst_err", 64'(a_err_cnt), 64'd0);
        drive(1'b0, 32'd0, 3'b000, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);

        // Streaming formats with out_ready held high
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 3'b000, 32'h11); cycle();
        head("i_type", 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 32'h11);
        drive(1'b1, 32'hFE000EE3, 3'b010, 32'h22); cycle();
        head("b_type", 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 32'h22);
        drive(1'b1, 32'h00A12423, 3'b001, 32'h23); cycle();
        head("s_type", 32'h8, 64'h8, 1'b0, 32'h23);
        drive(1'b1, 32'h7FFFF0EF, 3'b011, 32'h24); cycle();
        head("j_type", 32'h000FFFFE, 64'h000FFFFE, 1'b0, 32'h24);
        drive(1'b1, 32'h800000B7, 3'b100, 32'h61); cycle();
        head("u_type", 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0, 32'h61);
        drive(1'b1, 32'h000F8000, 3'b101, 32'h62); cycle();
        head("z_type", 32'h1F, 64'h1F, 1'b0, 32'h62);
        drive(1'b1, 32'h03F00000, 3'b110, 32'h63); cycle();
        head("sh_type", 32'h1F, 64'h3F, 1'b0, 32'h63);
        drive(1'b0, 32'd0, 3'b000, 32'd0); cycle();
        chk("drain_valid", 64'(a_out_valid), 64'd0);

        // Backpressure: A,B fill the buffer, C waits
        out_ready = 1'b0;
        drive(1'b1, 32'h00500093, 3'b000, 32'hA1); cycle();
        chk("bp_ready_half", 64'(a_in_ready), 64'd1);
        drive(1'b1, 32'h00600093, 3'b000, 32'hB2); cycle();
        chk("bp_ready_full", 64'(a_in_ready), 64'd0);
        drive(1'b1, 32'h00700093, 3'b000, 32'hC3); cycle(); cycle();
        chk("bp_ready_held", 64'(a_in_ready), 64'd0);
        head("bp_A_stable", 32'h5, 64'h5, 1'b0, 32'hA1);
        out_ready = 1'b1; cycle();
        head("bp_B", 32'h6, 64'h6, 1'b0, 32'hB2);
        cycle();
        drive(1'b0, 32'd0, 3'b000, 32'd0);
        head("bp_C", 32'h7, 64'h7, 1'b0, 32'hC3);
        cycle();
        chk("bp_empty", 64'(a_out_valid), 64'd0);

        // Flush while FULL, with an illegal entry offered in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 32'h00800093, 3'b000, 32'hD4); cycle();
        drive(1'b1, 32'h00900093, 3'b000, 32'hE5); cycle();
        chk("fl_full", 64'(a_in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'hFFFFFFFF, 3'b111, 32'hF6); cycle();
        flush = 1'b0;
        drive(1'b0, 32'd0, 3'b000, 32'd0);
        chk("fl_valid", 64'(a_out_valid), 64'd0);
        chk("fl_ready", 64'(a_in_ready), 64'd1);
        chk("fl_err32", 64'(a_err_cnt), 64'd0);
        chk("fl_err64", 64'(b_err_cnt), 64'd0);
        cycle();
        chk("fl_no_ghost", 64'(b_out_valid), 64'd0);
        $display("txn flush valid=%0b ready=%0b err=%0d", a_out_valid, a_in_ready, a_err_cnt);

        // Illegal format: 2-bit counter saturates at 3, 8-bit keeps counting
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hFFFFFFFF, 3'b111, 32'h70 + 32'(i)); cycle();
            head("illegal", 32'd0, 64'd0, 1'b1, 32'h70 + 32'(i));
            chk("ill_flag64", 64'(b_illegal), 64'd1);
            chk("ill_err32", 64'(a_err_cnt), 64'(i + 1));
            chk("ill_err64", 64'(b_err_cnt), (i + 1 > 3) ? 64'd3 : 64'(i + 1));
        end
        drive(1'b0, 32'd0, 3'b000, 32'd0); cycle();
        chk("ill_drain", 64'(a_out_valid), 64'd0);

        // Reset mid-operation drops a buffered entry
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 3'b000, 32'h55); cycle();
        drive(1'b0, 32'd0, 3'b000, 32'd0);
        reset = 1'b1; cycle();
        reset = 1'b0;
        chk("mid_rst_valid", 64'(a_out_valid), 64'd0);
        chk("mid_rst_err", 64'(a_err_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
